// File: rtl/std_aes_optimized.sv
// AES-128 encryption controller for a compute-in-memory array that holds the round keys and S-box.
// AddRoundKey is bit-serial through the array; ShiftRows/MixColumns and sequencing are local.
module std_aes_optimized (
    input  logic         CLK,
    input  logic         RSTn,
    input  logic         EN,
    input  logic [127:0] Din,
    input  logic         KDrdy,
    input  logic [7:0]   RIO_00,
    input  logic [7:0]   RIO_01,
    input  logic [7:0]   RIO_02,
    input  logic [7:0]   RIO_03,
    input  logic [7:0]   RIO_04,
    input  logic [7:0]   RIO_05,
    input  logic [7:0]   RIO_06,
    input  logic [7:0]   RIO_07,
    input  logic [7:0]   RIO_08,
    input  logic [7:0]   RIO_09,
    input  logic [7:0]   RIO_10,
    input  logic [7:0]   RIO_11,
    input  logic [7:0]   RIO_12,
    input  logic [7:0]   RIO_13,
    input  logic [7:0]   RIO_14,
    input  logic [7:0]   RIO_15,
    output logic [15:0]  IN,
    output logic [2:0]   DEMUX_ADD_00,
    output logic [2:0]   DEMUX_ADD_01,
    output logic [2:0]   DEMUX_ADD_02,
    output logic [2:0]   DEMUX_ADD_03,
    output logic [2:0]   DEMUX_ADD_04,
    output logic [2:0]   DEMUX_ADD_05,
    output logic [2:0]   DEMUX_ADD_06,
    output logic [2:0]   DEMUX_ADD_07,
    output logic [2:0]   DEMUX_ADD_08,
    output logic [2:0]   DEMUX_ADD_09,
    output logic [2:0]   DEMUX_ADD_10,
    output logic [2:0]   DEMUX_ADD_11,
    output logic [2:0]   DEMUX_ADD_12,
    output logic [2:0]   DEMUX_ADD_13,
    output logic [2:0]   DEMUX_ADD_14,
    output logic [2:0]   DEMUX_ADD_15,
    output logic [5:0]   RWL_DEC_ADD_00,
    output logic [5:0]   RWL_DEC_ADD_01,
    output logic [5:0]   RWL_DEC_ADD_02,
    output logic [5:0]   RWL_DEC_ADD_03,
    output logic [5:0]   RWL_DEC_ADD_04,
    output logic [5:0]   RWL_DEC_ADD_05,
    output logic [5:0]   RWL_DEC_ADD_06,
    output logic [5:0]   RWL_DEC_ADD_07,
    output logic [5:0]   RWL_DEC_ADD_08,
    output logic [5:0]   RWL_DEC_ADD_09,
    output logic [5:0]   RWL_DEC_ADD_10,
    output logic [5:0]   RWL_DEC_ADD_11,
    output logic [5:0]   RWL_DEC_ADD_12,
    output logic [5:0]   RWL_DEC_ADD_13,
    output logic [5:0]   RWL_DEC_ADD_14,
    output logic [5:0]   RWL_DEC_ADD_15,
    output logic [127:0] Dout,
    output logic         Kvld,
    output logic         Dvld,
    output logic         BSY
);

    // state  | meaning
    // S_IDLE | waiting for EN & KDrdy
    // S_ARK  | r_cnt 8..1 issue key-pair 8-r_cnt, r_cnt 7..0 capture pair 7-r_cnt
    // S_SBOX | channel j addresses S-box entry of ARK byte j
    // S_MIX  | S-box data back: ShiftRows (+MixColumns unless round 9)
    typedef enum logic [1:0] {S_IDLE, S_ARK, S_SBOX, S_MIX} state_t;
    typedef logic [0:15][7:0] blk_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic blk_t shift_rows(input blk_t s);
        blk_t o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[4*c+r] = s[4*((c+r)%4)+r];
        return o;
    endfunction

    function automatic blk_t mix_columns(input blk_t s);
        blk_t       o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[4*c];
            a1 = s[4*c+1];
            a2 = s[4*c+2];
            a3 = s[4*c+3];
            o[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    state_t            r_fsm, w_fsm_nxt;
    blk_t              r_st, r_ark, w_ark_nxt, w_rio, w_sr;
    logic [3:0]        r_round;
    logic [3:0]        r_cnt;
    logic [127:0]      r_dout;
    logic              r_kvld, r_dvld;
    logic              w_start, w_done;
    logic [2:0]        w_t, w_c;
    logic [0:15][2:0]  w_dmx;
    logic [0:15][5:0]  w_rwl;

    assign w_rio = {RIO_00, RIO_01, RIO_02, RIO_03, RIO_04, RIO_05, RIO_06, RIO_07,
                    RIO_08, RIO_09, RIO_10, RIO_11, RIO_12, RIO_13, RIO_14, RIO_15};

    assign {DEMUX_ADD_00, DEMUX_ADD_01, DEMUX_ADD_02, DEMUX_ADD_03,
            DEMUX_ADD_04, DEMUX_ADD_05, DEMUX_ADD_06, DEMUX_ADD_07,
            DEMUX_ADD_08, DEMUX_ADD_09, DEMUX_ADD_10, DEMUX_ADD_11,
            DEMUX_ADD_12, DEMUX_ADD_13, DEMUX_ADD_14, DEMUX_ADD_15} = w_dmx;

    assign {RWL_DEC_ADD_00, RWL_DEC_ADD_01, RWL_DEC_ADD_02, RWL_DEC_ADD_03,
            RWL_DEC_ADD_04, RWL_DEC_ADD_05, RWL_DEC_ADD_06, RWL_DEC_ADD_07,
            RWL_DEC_ADD_08, RWL_DEC_ADD_09, RWL_DEC_ADD_10, RWL_DEC_ADD_11,
            RWL_DEC_ADD_12, RWL_DEC_ADD_13, RWL_DEC_ADD_14, RWL_DEC_ADD_15} = w_rwl;

    assign Dout = r_dout;
    assign Kvld = r_kvld;
    assign Dvld = r_dvld;
    assign BSY  = (r_fsm != S_IDLE);

    assign w_start = EN & KDrdy & (r_fsm == S_IDLE);
    assign w_done  = (r_fsm == S_ARK) & (r_cnt == 4'd0) & (r_round == 4'd10);
    // Issue pair index is 8-r_cnt (mod 8); the captured pair lags by one, so its RIO bit is r_cnt itself.
    assign w_t     = 3'd0 - r_cnt[2:0];
    assign w_c     = ~r_cnt[2:0];
    assign w_sr    = shift_rows(w_rio);

    always_ff @(posedge CLK) begin
        if (!RSTn)
            r_fsm <= S_IDLE;
        else
            r_fsm <= w_fsm_nxt;
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            S_IDLE:  if (w_start) w_fsm_nxt = S_ARK;
            S_ARK:   if (r_cnt == 4'd0) w_fsm_nxt = (r_round == 4'd10) ? S_IDLE : S_SBOX;
            S_SBOX:  w_fsm_nxt = S_MIX;
            S_MIX:   w_fsm_nxt = S_ARK;
            default: w_fsm_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        IN    = '0;
        w_dmx = '0;
        w_rwl = '0;
        case (r_fsm)
            S_ARK: begin
                if (r_cnt != 4'd0) begin
                    IN = {r_st[{w_t, 1'b0}], r_st[{w_t, 1'b1}]};
                    for (int j = 0; j < 16; j++) begin
                        w_dmx[j] = 3'b100;
                        w_rwl[j] = {2'b00, r_round};
                    end
                end
            end
            S_SBOX: begin
                for (int j = 0; j < 16; j++) begin
                    w_dmx[j] = {1'b0, r_ark[j][7:6]};
                    w_rwl[j] = r_ark[j][5:0];
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        w_ark_nxt = r_ark;
        for (int k = 0; k < 8; k++) begin
            w_ark_nxt[{w_c, 1'b0}][k] = w_rio[k][r_cnt[2:0]];
            w_ark_nxt[{w_c, 1'b1}][k] = w_rio[k+8][r_cnt[2:0]];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_st    <= '0;
            r_ark   <= '0;
            r_round <= '0;
            r_cnt   <= '0;
            r_dout  <= '0;
            r_kvld  <= 1'b0;
            r_dvld  <= 1'b0;
        end else begin
            r_kvld <= w_start;
            r_dvld <= w_done;
            case (r_fsm)
                S_IDLE: begin
                    if (w_start) begin
                        r_st    <= Din;
                        r_round <= 4'd0;
                        r_cnt   <= 4'd8;
                    end
                end
                S_ARK: begin
                    if (r_cnt != 4'd8) r_ark <= w_ark_nxt;
                    if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
                    if (w_done) r_dout <= w_ark_nxt;
                end
                S_MIX: begin
                    r_st    <= (r_round == 4'd9) ? w_sr : mix_columns(w_sr);
                    r_round <= r_round + 4'd1;
                    r_cnt   <= 4'd8;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_std_aes_optimized.sv
// Bench for std_aes_optimized: CIM array model, AES-128 reference, queue scoreboard.
module tb_std_aes_optimized;

    logic         CLK = 1'b0;
    logic         RSTn, EN, KDrdy;
    logic [127:0] Din;
    logic [7:0]   rio [16];
    logic [15:0]  IN;
    logic [2:0]   dmx [16];
    logic [5:0]   rwl [16];
    logic [127:0] Dout;
    logic         Kvld, Dvld, BSY;

    always #5 CLK = ~CLK;

    std_aes_optimized dut (
        .CLK(CLK), .RSTn(RSTn), .EN(EN), .Din(Din), .KDrdy(KDrdy),
        .RIO_00(rio[0]),  .RIO_01(rio[1]),  .RIO_02(rio[2]),  .RIO_03(rio[3]),
        .RIO_04(rio[4]),  .RIO_05(rio[5]),  .RIO_06(rio[6]),  .RIO_07(rio[7]),
        .RIO_08(rio[8]),  .RIO_09(rio[9]),  .RIO_10(rio[10]), .RIO_11(rio[11]),
        .RIO_12(rio[12]), .RIO_13(rio[13]), .RIO_14(rio[14]), .RIO_15(rio[15]),
        .IN(IN),
        .DEMUX_ADD_00(dmx[0]),  .DEMUX_ADD_01(dmx[1]),  .DEMUX_ADD_02(dmx[2]),  .DEMUX_ADD_03(dmx[3]),
        .DEMUX_ADD_04(dmx[4]),  .DEMUX_ADD_05(dmx[5]),  .DEMUX_ADD_06(dmx[6]),  .DEMUX_ADD_07(dmx[7]),
        .DEMUX_ADD_08(dmx[8]),  .DEMUX_ADD_09(dmx[9]),  .DEMUX_ADD_10(dmx[10]), .DEMUX_ADD_11(dmx[11]),
        .DEMUX_ADD_12(dmx[12]), .DEMUX_ADD_13(dmx[13]), .DEMUX_ADD_14(dmx[14]), .DEMUX_ADD_15(dmx[15]),
        .RWL_DEC_ADD_00(rwl[0]),  .RWL_DEC_ADD_01(rwl[1]),  .RWL_DEC_ADD_02(rwl[2]),  .RWL_DEC_ADD_03(rwl[3]),
        .RWL_DEC_ADD_04(rwl[4]),  .RWL_DEC_ADD_05(rwl[5]),  .RWL_DEC_ADD_06(rwl[6]),  .RWL_DEC_ADD_07(rwl[7]),
        .RWL_DEC_ADD_08(rwl[8]),  .RWL_DEC_ADD_09(rwl[9]),  .RWL_DEC_ADD_10(rwl[10]), .RWL_DEC_ADD_11(rwl[11]),
        .RWL_DEC_ADD_12(rwl[12]), .RWL_DEC_ADD_13(rwl[13]), .RWL_DEC_ADD_14(rwl[14]), .RWL_DEC_ADD_15(rwl[15]),
        .Dout(Dout), .Kvld(Kvld), .Dvld(Dvld), .BSY(BSY)
    );

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] ZERO_CT  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    int           n_cmp = 0;
    int           n_err = 0;
    logic [7:0]   sbox   [256];
    logic [7:0]   rk     [11][16];
    logic [7:0]   ref_st [11][16];
    logic [127:0] exp_q  [$];
    bit           m_busy = 0, exp_kvld = 0, exp_dvld = 0, chk_en = 0;
    int           m_cnt = 0;
    logic [127:0] m_dout = '0;

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: GF(2^8) inverse (x^254) followed by the affine map
    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv, base;
        int         e;
        inv = 8'h01; base = x; e = 254;
        while (e > 0) begin
            if (e % 2 == 1) inv = gmul(inv, base);
            base = gmul(base, base);
            e = e / 2;
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]} ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++)
            for (int c = 0; c < 4; c++)
                for (int b = 0; b < 4; b++)
                    rk[r][4*c+b] = w[4*r+c][31-8*b -: 8];
    endtask

    // Reference cipher; also records each round's input state for the pin checker
    task automatic ref_encrypt(input logic [127:0] pt, output logic [127:0] ct);
        logic [7:0] s [16];
        logic [7:0] t2 [16];
        logic [7:0] a0, a1, a2, a3;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 16; i++) ref_st[r][i] = s[i];
            for (int i = 0; i < 16; i++) s[i] = sbox[s[i] ^ rk[r][i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t2[4*c+row] = s[4*((c+row)%4)+row];
            for (int c = 0; c < 4; c++) begin
                a0 = t2[4*c]; a1 = t2[4*c+1]; a2 = t2[4*c+2]; a3 = t2[4*c+3];
                if (r < 9) begin
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
        end
        for (int i = 0; i < 16; i++) begin
            ref_st[10][i] = s[i];
            ct[127-8*i -: 8] = s[i] ^ rk[10][i];
        end
    endtask

    // CIM array: samples pins at each edge, presents read data for the following cycle
    logic [8:0] am_a;
    logic [7:0] am_v;
    int         am_r;
    always @(posedge CLK) begin
        for (int j = 0; j < 16; j++) begin
            am_a = {dmx[j], rwl[j]};
            am_v = 8'h00;
            if (am_a < 9'h100) begin
                am_v = sbox[am_a[7:0]];
            end else if (am_a[7:0] <= 8'd10) begin
                am_r = int'(am_a[7:0]);
                for (int m = 0; m < 8; m++) begin
                    if (j < 8) am_v[7-m] = rk[am_r][2*m][j] ^ IN[8+j];
                    else       am_v[7-m] = rk[am_r][2*m+1][j-8] ^ IN[j-8];
                end
            end
            rio[j] <= am_v;
        end
    end

    // Timing model: accept, 119-edge busy window, expected ciphertext into the scoreboard
    logic [127:0] mdl_ct;
    always @(posedge CLK) begin
        if (!RSTn) begin
            chk_en = 1; m_busy = 0; m_cnt = 0; exp_kvld = 0; exp_dvld = 0;
            exp_q.delete();
        end else begin
            exp_kvld = 0; exp_dvld = 0;
            if (m_busy) begin
                m_cnt--;
                if (m_cnt == 0) begin m_busy = 0; exp_dvld = 1; end
            end else if (EN && KDrdy) begin
                ref_encrypt(Din, mdl_ct);
                exp_q.push_back(mdl_ct);
                m_busy = 1; m_cnt = 119; exp_kvld = 1;
            end
        end
    end

    logic [159:0] mon_pa, mon_pe;
    logic [127:0] mon_exp;
    logic [7:0]   mon_b;
    int           mon_e, mon_r, mon_t;
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("kvld", 160'(Kvld), 160'(exp_kvld));
            chk("dvld", 160'(Dvld), 160'(exp_dvld));
            chk("bsy",  160'(BSY),  160'(m_busy));
            if (!RSTn) begin
                m_dout = '0;
            end else if (Dvld) begin
                if (exp_q.size() == 0) begin
                    chk("dout_unexpected", 160'(Dvld), 160'(0));
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("dout", 160'(Dout), 160'(mon_exp));
                    m_dout = mon_exp;
                end
            end else begin
                chk("dout_hold", 160'(Dout), 160'(m_dout));
            end
            mon_pa = '0;
            mon_pe = '0;
            mon_pa[159:144] = IN;
            for (int j = 0; j < 16; j++) begin
                mon_pa[143-3*j -: 3] = dmx[j];
                mon_pa[95-6*j -: 6]  = rwl[j];
            end
            if (m_busy) begin
                mon_e = 119 - m_cnt;
                if (mon_e < 110) begin mon_r = mon_e / 11; mon_t = mon_e % 11; end
                else             begin mon_r = 10;         mon_t = mon_e - 110; end
                if (mon_t <= 7) begin
                    mon_pe[159:144] = {ref_st[mon_r][2*mon_t], ref_st[mon_r][2*mon_t+1]};
                    for (int j = 0; j < 16; j++) begin
                        mon_pe[143-3*j -: 3] = 3'b100;
                        mon_pe[95-6*j -: 6]  = 6'(mon_r);
                    end
                end else if (mon_t == 9) begin
                    for (int j = 0; j < 16; j++) begin
                        mon_b = ref_st[mon_r][j] ^ rk[mon_r][j];
                        mon_pe[143-3*j -: 3] = {1'b0, mon_b[7:6]};
                        mon_pe[95-6*j -: 6]  = mon_b[5:0];
                    end
                end
            end
            chk("pins", mon_pa, mon_pe);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_once(input logic [127:0] d);
        EN = 1'b1; KDrdy = 1'b1; Din = d;
        tick();
        EN = 1'b0; KDrdy = 1'b0;
    endtask

    task automatic wait_dvld(input int lim);
        bit got;
        got = 0;
        for (int i = 0; i < lim && !got; i++) begin
            tick();
            if (Dvld) got = 1;
        end
        chk("dvld_timeout", 160'(got), 160'(1));
    endtask

    task automatic wait_idle(input int lim);
        bit got;
        got = 0;
        for (int i = 0; i < lim && !got; i++) begin
            tick();
            if (!BSY) got = 1;
        end
        chk("idle_timeout", 160'(got), 160'(1));
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        RSTn = 1'b0; EN = 1'b0; KDrdy = 1'b0; Din = '0;
        for (int i = 0; i < 256; i++) sbox[i] = sbox_calc(8'(i));
        expand_key(FIPS_KEY);
        repeat (3) tick();
        RSTn = 1'b1;
        tick();

        start_once(FIPS_PT);
        wait_dvld(130);
        chk("fips_ct", 160'(Dout), 160'(FIPS_CT));

        expand_key('0);
        tick();
        start_once('0);
        wait_dvld(130);
        chk("zero_ct", 160'(Dout), 160'(ZERO_CT));
        start_once('0);
        wait_dvld(130);
        chk("zero_ct_b2b", 160'(Dout), 160'(ZERO_CT));

        expand_key(FIPS_KEY);
        tick();
        start_once(FIPS_PT);
        repeat (50) tick();
        EN = 1'b1; KDrdy = 1'b1; Din = rnd128();
        tick();
        EN = 1'b0; KDrdy = 1'b0;
        wait_dvld(130);
        chk("fips_ct_kdrdy_midrun", 160'(Dout), 160'(FIPS_CT));

        KDrdy = 1'b1;
        repeat (5) tick();
        KDrdy = 1'b0;
        chk("en0_no_start", 160'(BSY), 160'(0));
        tick();

        start_once(FIPS_PT);
        repeat (5*11 + 2) tick();
        RSTn = 1'b0;
        tick();
        RSTn = 1'b1;
        chk("rst_bsy",  160'(BSY), 160'(0));
        chk("rst_dout", 160'(Dout), 160'(0));
        chk("rst_in",   160'(IN), 160'(0));
        chk("rst_vld",  160'({Kvld, Dvld}), 160'(0));
        tick();
        start_once(FIPS_PT);
        wait_dvld(130);
        chk("fips_ct_after_rst", 160'(Dout), 160'(FIPS_CT));

        expand_key(rnd128());
        tick();
        EN = 1'b1; KDrdy = 1'b1;
        for (int i = 0; i < 3*119 + 5; i++) begin
            Din = rnd128();
            tick();
        end
        EN = 1'b0; KDrdy = 1'b0;
        wait_idle(250);

        for (int it = 0; it < 6; it++) begin
            expand_key(rnd128());
            repeat ($urandom_range(1, 5)) tick();
            start_once(rnd128());
            wait_dvld(130);
        end
        repeat (3) tick();
        chk("queue_empty", 160'(exp_q.size()), 160'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
